// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the owner-hold rule used by the two-master arbiter.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Owner keeps the bus mid-burst, or for any active phase of a locked sequence.
   function automatic logic owner_hold(input logic [1:0] htrans, input logic hlock);
      return (htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ) ||
             (hlock && (htrans != HTRANS_IDLE));
   endfunction

endpackage

// File: rtl/ahb_arb_rr.sv
// Two-way round-robin grant decision, purely combinational; default master is 0.
module ahb_arb_rr
   import ahb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_last,
   input  logic       hold,
   input  logic       cur,
   output logic [1:0] gnt_next
);

   always_comb begin
      gnt_next = 2'b01;
      if (hold) begin
         gnt_next = cur ? 2'b10 : 2'b01;
      end else begin
         case (req)
            2'b01:   gnt_next = 2'b01;
            2'b10:   gnt_next = 2'b10;
            2'b11:   gnt_next = rr_last ? 2'b01 : 2'b10;
            default: gnt_next = 2'b01;
         endcase
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter + address/data mux; grant 1 cycle after request,
// address ownership one hready edge later; hready=0 freezes all arbiter state.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 40,
   parameter int DATA_W = 128
)
(
   input  logic              pll_core_cpuclk,
   input  logic              pad_cpu_rst_b,
   input  logic              m0_hbusreq,
   input  logic              m1_hbusreq,
   input  logic              m0_hlock,
   input  logic              m1_hlock,
   input  logic [1:0]        m0_htrans,
   input  logic [1:0]        m1_htrans,
   input  logic [ADDR_W-1:0] m0_haddr,
   input  logic [ADDR_W-1:0] m1_haddr,
   input  logic              m0_hwrite,
   input  logic              m1_hwrite,
   input  logic [2:0]        m0_hsize,
   input  logic [2:0]        m1_hsize,
   input  logic [2:0]        m0_hburst,
   input  logic [2:0]        m1_hburst,
   input  logic [3:0]        m0_hprot,
   input  logic [3:0]        m1_hprot,
   input  logic [DATA_W-1:0] m0_hwdata,
   input  logic [DATA_W-1:0] m1_hwdata,
   input  logic              hready,
   output logic              m0_hgrant,
   output logic              m1_hgrant,
   output logic              hmaster,
   output logic              hmastlock,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [3:0]        hprot,
   output logic [DATA_W-1:0] hwdata
);

   logic [1:0] grant;
   logic [1:0] grant_next;
   logic       data_owner;
   logic       rr_last;
   logic       hold;
   logic       winner;
   logic [1:0] req;

   assign req    = {m1_hbusreq, m0_hbusreq};
   assign hold   = hmaster ? owner_hold(m1_htrans, m1_hlock)
                           : owner_hold(m0_htrans, m0_hlock);
   assign winner = grant_next[1];

   ahb_arb_rr u_rr (
      .req      (req),
      .rr_last  (rr_last),
      .hold     (hold),
      .cur      (grant[1]),
      .gnt_next (grant_next)
   );

   // hmaster trails grant by one completed transfer; data_owner trails hmaster likewise.
   always_ff @(posedge pll_core_cpuclk) begin
      if (!pad_cpu_rst_b) begin
         grant      <= 2'b01;
         hmaster    <= 1'b0;
         data_owner <= 1'b0;
         rr_last    <= 1'b0;
      end else if (hready) begin
         grant      <= grant_next;
         hmaster    <= grant[1];
         data_owner <= hmaster;
         if (!hold && req[winner]) begin
            rr_last <= winner;
         end
      end
   end

   assign m0_hgrant = grant[0];
   assign m1_hgrant = grant[1];

   always_comb begin
      hmastlock = m0_hlock;
      haddr     = m0_haddr;
      htrans    = m0_htrans;
      hwrite    = m0_hwrite;
      hsize     = m0_hsize;
      hburst    = m0_hburst;
      hprot     = m0_hprot;
      if (hmaster) begin
         hmastlock = m1_hlock;
         haddr     = m1_haddr;
         htrans    = m1_htrans;
         hwrite    = m1_hwrite;
         hsize     = m1_hsize;
         hburst    = m1_hburst;
         hprot     = m1_hprot;
      end
   end

   assign hwdata = data_owner ? m1_hwdata : m0_hwdata;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed cycle-by-cycle vectors for the two-master arbiter, plus a hand-written stall sequence.
module tb_ahb_arbiter;
   import ahb_pkg::*;

   localparam int ADDR_W = 40;
   localparam int DATA_W = 128;
   localparam logic [1:0] I = HTRANS_IDLE;
   localparam logic [1:0] N = HTRANS_NONSEQ;
   localparam logic [1:0] S = HTRANS_SEQ;

   localparam logic [ADDR_W-1:0] A0 = 40'h00_1f00_0000;
   localparam logic [ADDR_W-1:0] A1 = 40'h00_2000_0040;
   localparam logic [DATA_W-1:0] D0 = {4{32'hA0A0_0000}};
   localparam logic [DATA_W-1:0] D1 = {4{32'hB1B1_1111}};

   logic              clk = 1'b0;
   logic              rst_b;
   logic              m0_hbusreq, m1_hbusreq, m0_hlock, m1_hlock;
   logic [1:0]        m0_htrans, m1_htrans;
   logic              hready;
   logic              m0_hgrant, m1_hgrant, hmaster, hmastlock, hwrite;
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic [2:0]        hsize, hburst;
   logic [3:0]        hprot;
   logic [DATA_W-1:0] hwdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst_b   (rst_b),
      .m0_hbusreq      (m0_hbusreq),
      .m1_hbusreq      (m1_hbusreq),
      .m0_hlock        (m0_hlock),
      .m1_hlock        (m1_hlock),
      .m0_htrans       (m0_htrans),
      .m1_htrans       (m1_htrans),
      .m0_haddr        (A0),
      .m1_haddr        (A1),
      .m0_hwrite       (1'b0),
      .m1_hwrite       (1'b1),
      .m0_hsize        (3'd2),
      .m1_hsize        (3'd4),
      .m0_hburst       (HBURST_INCR4),
      .m1_hburst       (HBURST_SINGLE),
      .m0_hprot        (4'h3),
      .m1_hprot        (4'hc),
      .m0_hwdata       (D0),
      .m1_hwdata       (D1),
      .hready          (hready),
      .m0_hgrant       (m0_hgrant),
      .m1_hgrant       (m1_hgrant),
      .hmaster         (hmaster),
      .hmastlock       (hmastlock),
      .haddr           (haddr),
      .htrans          (htrans),
      .hwrite          (hwrite),
      .hsize           (hsize),
      .hburst          (hburst),
      .hprot           (hprot),
      .hwdata          (hwdata)
   );

   typedef struct {
      logic       rst_b;
      logic       hready;
      logic [1:0] req;
      logic [1:0] lock;
      logic [1:0] t0;
      logic [1:0] t1;
      logic       e_g1;
      logic       e_hm;
      logic       e_lock;
      logic [1:0] e_trans;
      logic       e_dsel;
   } vec_t;

   function automatic vec_t v(input logic r, input logic rdy, input logic [1:0] req,
                              input logic [1:0] lock, input logic [1:0] t0, input logic [1:0] t1,
                              input logic g1, input logic hm, input logic ml,
                              input logic [1:0] tr, input logic ds);
      vec_t x;
      x.rst_b = r;   x.hready = rdy; x.req = req; x.lock = lock;
      x.t0 = t0;     x.t1 = t1;      x.e_g1 = g1; x.e_hm = hm;
      x.e_lock = ml; x.e_trans = tr; x.e_dsel = ds;
      return x;
   endfunction

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      rst_b      = x.rst_b;
      hready     = x.hready;
      m0_hbusreq = x.req[0];
      m1_hbusreq = x.req[1];
      m0_hlock   = x.lock[0];
      m1_hlock   = x.lock[1];
      m0_htrans  = x.t0;
      m1_htrans  = x.t1;
   endtask

   task automatic check_vec(input string tag, input vec_t x);
      logic [ADDR_W+13:0] exp_af;
      exp_af = x.e_hm ? {A1, 1'b1, 3'd4, HBURST_SINGLE, 4'hc}
                      : {A0, 1'b0, 3'd2, HBURST_INCR4, 4'h3};
      chk({tag, " m0_hgrant"}, 192'(m0_hgrant), 192'(!x.e_g1));
      chk({tag, " m1_hgrant"}, 192'(m1_hgrant), 192'(x.e_g1));
      chk({tag, " hmaster"},   192'(hmaster),   192'(x.e_hm));
      chk({tag, " hmastlock"}, 192'(hmastlock), 192'(x.e_lock));
      chk({tag, " htrans"},    192'(htrans),    192'(x.e_trans));
      chk({tag, " addr_fields"}, 192'({haddr, hwrite, hsize, hburst, hprot}), 192'(exp_af));
      chk({tag, " hwdata"},    192'(hwdata),    192'(x.e_dsel ? D1 : D0));
   endtask

   vec_t vecs[42];

   initial begin
      // rst,rdy,req,lock,t0,t1 | g1,hm,mastlock,htrans,dsel
      vecs[0]  = v(1,1,2'b00,2'b00,N,I, 0,0,0,N,0); // reset state, m0 NONSEQ
      vecs[1]  = v(1,1,2'b10,2'b00,I,I, 0,0,0,I,0); // m1 requests
      vecs[2]  = v(1,1,2'b10,2'b00,I,I, 1,0,0,I,0);
      vecs[3]  = v(1,1,2'b10,2'b00,I,N, 1,1,0,N,0);
      vecs[4]  = v(1,1,2'b00,2'b00,I,I, 1,1,0,I,1);
      vecs[5]  = v(1,1,2'b00,2'b00,I,I, 0,1,0,I,1);
      vecs[6]  = v(1,1,2'b00,2'b00,I,I, 0,0,0,I,1);
      vecs[7]  = v(1,1,2'b11,2'b00,N,N, 0,0,0,N,0); // both request, rr_last=1
      vecs[8]  = v(1,1,2'b11,2'b00,N,N, 0,0,0,N,0);
      vecs[9]  = v(1,1,2'b11,2'b00,N,N, 1,0,0,N,0);
      vecs[10] = v(1,1,2'b11,2'b00,N,N, 0,1,0,N,0);
      vecs[11] = v(1,1,2'b11,2'b00,N,N, 1,0,0,N,1);
      vecs[12] = v(1,1,2'b11,2'b00,N,N, 0,1,0,N,0);
      vecs[13] = v(1,1,2'b00,2'b00,I,I, 1,0,0,I,1);
      vecs[14] = v(1,1,2'b00,2'b00,I,I, 0,1,0,I,0);
      vecs[15] = v(1,1,2'b00,2'b00,I,I, 0,0,0,I,1);
      vecs[16] = v(1,1,2'b01,2'b00,N,I, 0,0,0,N,0); // m0 INCR4 beat 1
      vecs[17] = v(1,1,2'b11,2'b00,S,I, 0,0,0,S,0); // beat 2, m1 requesting
      vecs[18] = v(1,0,2'b11,2'b00,S,I, 0,0,0,S,0); // stall x3
      vecs[19] = v(1,0,2'b11,2'b00,S,I, 0,0,0,S,0);
      vecs[20] = v(1,0,2'b11,2'b00,S,I, 0,0,0,S,0);
      vecs[21] = v(1,1,2'b11,2'b00,S,I, 0,0,0,S,0); // beat 3
      vecs[22] = v(1,1,2'b11,2'b00,S,I, 0,0,0,S,0); // beat 4
      vecs[23] = v(1,1,2'b10,2'b00,I,I, 0,0,0,I,0); // release
      vecs[24] = v(1,1,2'b10,2'b00,I,I, 1,0,0,I,0);
      vecs[25] = v(1,1,2'b00,2'b00,I,I, 1,1,0,I,0);
      vecs[26] = v(1,1,2'b00,2'b00,I,I, 0,1,0,I,1);
      vecs[27] = v(1,1,2'b00,2'b00,I,I, 0,0,0,I,1);
      vecs[28] = v(1,1,2'b10,2'b10,I,I, 0,0,0,I,0); // m1 locked sequence
      vecs[29] = v(1,1,2'b10,2'b10,I,I, 1,0,0,I,0);
      vecs[30] = v(1,1,2'b11,2'b10,I,N, 1,1,1,N,0);
      vecs[31] = v(1,1,2'b11,2'b10,I,N, 1,1,1,N,1);
      vecs[32] = v(1,1,2'b01,2'b00,I,I, 1,1,0,I,1);
      vecs[33] = v(1,1,2'b01,2'b00,I,I, 0,1,0,I,1);
      vecs[34] = v(1,1,2'b01,2'b00,N,I, 0,0,0,N,1);
      vecs[35] = v(1,1,2'b10,2'b00,I,I, 0,0,0,I,0); // m1 burst then reset
      vecs[36] = v(1,1,2'b10,2'b00,I,I, 1,0,0,I,0);
      vecs[37] = v(1,1,2'b10,2'b00,I,N, 1,1,0,N,0);
      vecs[38] = v(0,1,2'b10,2'b00,I,S, 1,1,0,S,1);
      vecs[39] = v(1,1,2'b00,2'b00,I,I, 0,0,0,I,0);
      vecs[40] = v(1,1,2'b11,2'b00,I,I, 0,0,0,I,0); // first tie after reset -> m1
      vecs[41] = v(1,1,2'b00,2'b00,I,I, 1,0,0,I,0);

      drive(v(0,1,2'b00,2'b00,I,I, 0,0,0,I,0));
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 42; k++) begin
         drive(vecs[k]);
         @(negedge clk);
         check_vec($sformatf("vec%0d", k), vecs[k]);
         @(posedge clk);
         #1;
      end

      // Stall with m1 requesting: grant must not move until hready returns.
      drive(v(1,0,2'b10,2'b00,I,I, 0,1,0,I,0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d m1_hgrant", k), 192'(m1_hgrant), 192'(1'b0));
         chk($sformatf("stall%0d hmaster", k), 192'(hmaster), 192'(1'b1));
         @(posedge clk);
         #1;
      end
      hready = 1'b1;
      @(posedge clk);
      #1;
      hready = 1'b0;
      @(negedge clk);
      chk("post_stall m1_hgrant", 192'(m1_hgrant), 192'(1'b1));
      chk("post_stall hmaster",   192'(hmaster),   192'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
